eth_rx_dispatch: RTL and testbench
==================================

# eth_rx_dispatch

Receive-side frame dispatcher placed directly after the Ethernet data layer. For each frame it checks the destination MAC and EtherType, then routes the payload stream (start, valid, end, 32-bit data) to exactly one upper-layer channel: IP or ARP. Frames that fail the checks are dropped. Per-class frame counters are kept for status readback.

## Interface
Parameters:
- ETH_IP, 16'h0800: EtherType routed to the IP channel.
- ETH_ARP, 16'h0806: EtherType routed to the ARP channel.
- ACCEPT_MCAST, 1: 1 accepts group addresses (dest bit 40 set); 0 drops them, except broadcast.
- CNT_W, 16: counter width.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset. One clock; reset is asynchronous and active-low.
- upper_op_st, in, 1: one-cycle payload-start pulse from the data layer.
- upper_op, in, 1: payload word valid.
- upper_op_end, in, 1: one-cycle payload-end pulse.
- upper_data, in, 32: payload word, valid when upper_op=1.
- dest_addr_i, in, 48: destination MAC; stable from before upper_op_st until the next frame.
- prot_type_i, in, 16: EtherType; same stability as dest_addr_i.
- local_mac, in, 48: station address; quasi-static.
- promisc, in, 1: 1 accepts any destination MAC.
- cnt_clr, in, 1: synchronous clear of all counters.
- ip_op_st, ip_op, ip_op_end, out, 1 each: IP channel strobes.
- ip_data, out, 32: IP channel data.
- arp_op_st, arp_op, arp_op_end, out, 1 each: ARP channel strobes.
- arp_data, out, 32: ARP channel data.
- cnt_ip, cnt_arp, cnt_drop, cnt_runt, out, CNT_W each: frame counters.

## Operation
- FSM states: IDLE, FWD_IP, FWD_ARP, DROP.
- Address match (mac_ok) is true when any of these holds:
  - promisc=1;
  - dest_addr_i equals local_mac;
  - dest_addr_i equals 48'hFFFF_FFFF_FFFF;
  - ACCEPT_MCAST=1 and dest_addr_i[40]=1.
- Routing decision, made on the upper_op_st cycle, in any state:
  - mac_ok and type equals ETH_IP: go to FWD_IP, increment cnt_ip.
  - mac_ok and type equals ETH_ARP: go to FWD_ARP, increment cnt_arp.
  - Otherwise: go to DROP, increment cnt_drop.
- The routing decision for the start cycle is evaluated combinationally. Later cycles of the frame use the latched state.
- Forwarding:
  - In the selected route, upper_op_st, upper_op, upper_op_end and upper_data are copied to that channel.
  - Both channels' data outputs are 32'h0 whenever their op is 0.
  - The unselected channel, and both channels in DROP, stay all-zero.
- upper_op_end in FWD_IP, FWD_ARP or DROP: the end pulse is forwarded in that route, then the FSM goes to IDLE.
- upper_op_end in IDLE with no start: this is a runt (frame ended before payload). Increment cnt_runt; no output.
- upper_op_st and upper_op_end in the same cycle: route, forward both pulses in one output cycle, count the frame, and end in IDLE.
- upper_op_st while in FWD_IP or FWD_ARP (previous end lost):
  - The old channel gets an op_end pulse in the same output cycle as the new frame's op_st.
  - If the old and new channel are the same, op_end and op_st assert together.
- Counters:
  - All counters wrap modulo 2^CNT_W.
  - cnt_clr takes priority over an increment in the same cycle.
- upper_op outside a frame (IDLE with no start) is ignored.

## Timing
- All outputs are registered. Input cycle N appears on the outputs at cycle N+1, so latency is fixed at 1 cycle.
- The start cycle is routed without extra delay, so the first payload word is not lost.
- Counters update at N+1 for a decision or runt event at N.
- Reset values:
  - FSM in IDLE.
  - All strobes 0, all data 32'h0, all counters 0.
- Reset is asynchronous and may be asserted mid-frame. Outputs drop to 0 immediately, with no end pulse. After release, words are ignored until the next upper_op_st.
- local_mac, promisc and the parameters are sampled only on the start cycle. Changing them mid-frame has no effect on the frame in progress.

## Test plan
- **Unicast IP.** local_mac=02:00:00:00:00:01, dest matches, type 0x0800, 6 words 0x11111111..0x66666666 with start on word 1 and end on word 6.
  - Expect ip_* to mirror the input delayed by 1 cycle.
  - Expect arp_* all 0 and cnt_ip=1.
- **Broadcast ARP vs. unknown type.**
  - dest FF:FF:FF:FF:FF:FF, type 0x0806, 3 words: expect arp channel forwarding and cnt_arp=1.
  - Repeat with type 0x86DD: expect no output and cnt_drop=1.
- **MAC miss and promiscuous mode.**
  - dest 02:00:00:00:00:02 with promisc=0: expect drop, cnt_drop increments.
  - Same frame with promisc=1: expect forwarding on IP.
- **Runt and single-word frame.**
  - End pulse with no start: expect cnt_runt=1 and outputs idle.
  - Start and end in the same cycle with data 0xDEADBEEF: expect ip_op_st, ip_op and ip_op_end all set in one cycle, ip_data=0xDEADBEEF, FSM back in IDLE.
- **Lost end.**
  - IP frame, then a new start for an ARP frame with no end in between: expect ip_op_end and arp_op_st in the same cycle.
  - Repeat with an IP→IP sequence: expect ip_op_end and ip_op_st together.
- **Reset and clear.**
  - Assert rst_n=0 mid-frame: outputs go to 0 asynchronously; after release, trailing words are ignored.
  - Assert cnt_clr in the same cycle as a start: counter reads 0 afterwards.
  - Run 2^CNT_W+1 IP frames: expect cnt_ip=1.

Source files
------------

// File: rtl/eth_rx_dispatch.sv
// Receive-side frame dispatcher: qualifies each frame by destination MAC and EtherType,
// then steers the payload stream to the IP or ARP channel with a fixed one-cycle latency.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no frame open; words and stray ends are not forwarded
// FWD_IP  | frame accepted, payload copied to the ip_* channel
// FWD_ARP | frame accepted, payload copied to the arp_* channel
// DROP    | frame rejected, payload discarded until its end pulse
module eth_rx_dispatch #(
  parameter logic [15:0] ETH_IP       = 16'h0800,
  parameter logic [15:0] ETH_ARP      = 16'h0806,
  parameter bit          ACCEPT_MCAST = 1'b1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upper_op_st,
  input  logic             upper_op,
  input  logic             upper_op_end,
  input  logic [31:0]      upper_data,
  input  logic [47:0]      dest_addr_i,
  input  logic [15:0]      prot_type_i,
  input  logic [47:0]      local_mac,
  input  logic             promisc,
  input  logic             cnt_clr,
  output logic             ip_op_st,
  output logic             ip_op,
  output logic             ip_op_end,
  output logic [31:0]      ip_data,
  output logic             arp_op_st,
  output logic             arp_op,
  output logic             arp_op_end,
  output logic [31:0]      arp_data,
  output logic [CNT_W-1:0] cnt_ip,
  output logic [CNT_W-1:0] cnt_arp,
  output logic [CNT_W-1:0] cnt_drop,
  output logic [CNT_W-1:0] cnt_runt
);

  typedef enum logic [1:0] {IDLE, FWD_IP, FWD_ARP, DROP} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t route_new;
  state_t route_cur;
  logic   mac_ok;
  logic   runt;

  // The start cycle is steered by the live decision so its word is not lost.
  always_comb begin
    mac_ok = promisc
          || (dest_addr_i == local_mac)
          || (dest_addr_i == 48'hFFFF_FFFF_FFFF)
          || (ACCEPT_MCAST && dest_addr_i[40]);
    route_new = DROP;
    if (mac_ok && (prot_type_i == ETH_IP))
      route_new = FWD_IP;
    else if (mac_ok && (prot_type_i == ETH_ARP))
      route_new = FWD_ARP;
    route_cur = upper_op_st ? route_new : state;
    runt      = upper_op_end && !upper_op_st && (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ip_op_st   <= 1'b0;
      ip_op      <= 1'b0;
      ip_op_end  <= 1'b0;
      ip_data    <= 32'h0;
      arp_op_st  <= 1'b0;
      arp_op     <= 1'b0;
      arp_op_end <= 1'b0;
      arp_data   <= 32'h0;
      cnt_ip     <= '0;
      cnt_arp    <= '0;
      cnt_drop   <= '0;
      cnt_runt   <= '0;
    end else begin
      ip_op_st   <= upper_op_st && (route_new == FWD_IP);
      ip_op      <= upper_op && (route_cur == FWD_IP);
      ip_data    <= (upper_op && (route_cur == FWD_IP)) ? upper_data : 32'h0;
      arp_op_st  <= upper_op_st && (route_new == FWD_ARP);
      arp_op     <= upper_op && (route_cur == FWD_ARP);
      arp_data   <= (upper_op && (route_cur == FWD_ARP)) ? upper_data : 32'h0;
      // A start inside an open frame closes the old channel in the same output cycle.
      ip_op_end  <= (upper_op_end && (route_cur == FWD_IP))
                 || (upper_op_st && (state == FWD_IP));
      arp_op_end <= (upper_op_end && (route_cur == FWD_ARP))
                 || (upper_op_st && (state == FWD_ARP));

      if (upper_op_st)
        state <= upper_op_end ? IDLE : route_new;
      else if (upper_op_end)
        state <= IDLE;

      if (cnt_clr) begin
        cnt_ip   <= '0;
        cnt_arp  <= '0;
        cnt_drop <= '0;
        cnt_runt <= '0;
      end else begin
        if (upper_op_st) begin
          case (route_new)
            FWD_IP:  cnt_ip   <= cnt_ip + CNT_ONE;
            FWD_ARP: cnt_arp  <= cnt_arp + CNT_ONE;
            default: cnt_drop <= cnt_drop + CNT_ONE;
          endcase
        end
        if (runt)
          cnt_runt <= cnt_runt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Bench for eth_rx_dispatch: directed vector table, reset/clear/wrap sequences,
// then random traffic against a frame-level reference model.
module tb_eth_rx_dispatch;

  localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st, op, en, prom, clr;
  logic [31:0] data;
  logic [47:0] dest, lmac;
  logic [15:0] ptype;

  logic        ip_op_st, ip_op, ip_op_end, arp_op_st, arp_op, arp_op_end;
  logic [31:0] ip_data, arp_data;
  logic [15:0] cnt_ip, cnt_arp, cnt_drop, cnt_runt;
  logic [69:0] dut_out;

  always #5 clk = ~clk;

  eth_rx_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .upper_op_st(st), .upper_op(op), .upper_op_end(en), .upper_data(data),
    .dest_addr_i(dest), .prot_type_i(ptype), .local_mac(lmac), .promisc(prom),
    .cnt_clr(clr),
    .ip_op_st(ip_op_st), .ip_op(ip_op), .ip_op_end(ip_op_end), .ip_data(ip_data),
    .arp_op_st(arp_op_st), .arp_op(arp_op), .arp_op_end(arp_op_end), .arp_data(arp_data),
    .cnt_ip(cnt_ip), .cnt_arp(cnt_arp), .cnt_drop(cnt_drop), .cnt_runt(cnt_runt)
  );

  assign dut_out = {ip_op_st, ip_op, ip_op_end, ip_data, arp_op_st, arp_op, arp_op_end, arp_data};

  int checks = 0;
  int failures = 0;

  // Reference: which channel the open frame belongs to (0 none, 1 ip, 2 arp, 3 discarded)
  // and frame tallies indexed 0 runt, 1 ip, 2 arp, 3 drop.
  int          m_route;
  int unsigned m_cnt[4];
  logic [69:0] exp_out;

  typedef struct {
    logic        st, op, en;
    logic [31:0] data;
    logic [47:0] dest;
    logic [15:0] ptype;
    logic        prom;
    logic [2:0]  ipb, arpb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic o, logic e, logic [31:0] d, logic [47:0] a,
                              logic [15:0] t, logic p, logic [2:0] ib, logic [2:0] ab);
    vec_t v;
    v.st = s; v.op = o; v.en = e; v.data = d; v.dest = a; v.ptype = t; v.prom = p;
    v.ipb = ib; v.arpb = ab;
    return v;
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic o, input logic e, input logic [31:0] d,
                       input logic [47:0] a, input logic [15:0] t, input logic p);
    st = s; op = o; en = e; data = d; dest = a; ptype = t; prom = p;
  endtask

  task automatic model_reset();
    m_route = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_cycle();
    logic        ok;
    int          nr;
    logic [2:0]  ipb, arpb;
    logic [31:0] ipd, arpd;
    ipb = 3'b000; arpb = 3'b000; ipd = 32'h0; arpd = 32'h0;
    ok = prom || (dest == lmac) || (dest == BCAST) || dest[40];
    if (st) begin
      nr = !ok ? 3 : (ptype == 16'h0800) ? 1 : (ptype == 16'h0806) ? 2 : 3;
      if (m_route == 1) ipb[0] = 1'b1;
      if (m_route == 2) arpb[0] = 1'b1;
      if (nr == 1) begin ipb = ipb | {1'b1, op, en}; ipd = op ? data : 32'h0; end
      if (nr == 2) begin arpb = arpb | {1'b1, op, en}; arpd = op ? data : 32'h0; end
      m_cnt[nr]++;
      m_route = en ? 0 : nr;
    end else if (m_route != 0) begin
      if (m_route == 1) begin ipb = {1'b0, op, en}; ipd = op ? data : 32'h0; end
      if (m_route == 2) begin arpb = {1'b0, op, en}; arpd = op ? data : 32'h0; end
      if (en) m_route = 0;
    end else if (en) begin
      m_cnt[0]++;
    end
    if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = m_cnt[i] & 32'hFFFF;
    exp_out = {ipb, ipd, arpb, arpd};
  endtask

  task automatic check_counters();
    check("cnt_runt", 70'(cnt_runt), 70'(m_cnt[0]));
    check("cnt_ip",   70'(cnt_ip),   70'(m_cnt[1]));
    check("cnt_arp",  70'(cnt_arp),  70'(m_cnt[2]));
    check("cnt_drop", 70'(cnt_drop), 70'(m_cnt[3]));
  endtask

  task automatic cyc();
    model_cycle();
    @(posedge clk);
    #1;
    check("outputs", dut_out, exp_out);
    check_counters();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; lmac = LMAC;
    drive(0, 0, 0, 32'h0, LMAC, 16'h0800, 0);
    model_reset();

    // Unicast IP, 6 words
    tbl.push_back(mk(1,1,0,32'h11111111,LMAC,16'h0800,0,3'b110,3'b000));
    tbl.push_back(mk(0,1,0,32'h22222222,LMAC,16'h0800,0,3'b010,3'b000));
    tbl.push_back(mk(0,1,0,32'h33333333,LMAC,16'h0800,0,3'b010,3'b000));
    tbl.push_back(mk(0,1,0,32'h44444444,LMAC,16'h0800,0,3'b010,3'b000));
    tbl.push_back(mk(0,1,0,32'h55555555,LMAC,16'h0800,0,3'b010,3'b000));
    tbl.push_back(mk(0,1,1,32'h66666666,LMAC,16'h0800,0,3'b011,3'b000));
    tbl.push_back(mk(0,1,0,32'h0BADF00D,LMAC,16'h0800,0,3'b000,3'b000));
    // Broadcast ARP, then unknown type
    tbl.push_back(mk(1,1,0,32'hA1A1A1A1,BCAST,16'h0806,0,3'b000,3'b110));
    tbl.push_back(mk(0,1,0,32'hA2A2A2A2,BCAST,16'h0806,0,3'b000,3'b010));
    tbl.push_back(mk(0,1,1,32'hA3A3A3A3,BCAST,16'h0806,0,3'b000,3'b011));
    tbl.push_back(mk(1,1,0,32'hB1B1B1B1,BCAST,16'h86DD,0,3'b000,3'b000));
    tbl.push_back(mk(0,1,0,32'hB2B2B2B2,BCAST,16'h86DD,0,3'b000,3'b000));
    tbl.push_back(mk(0,1,1,32'hB3B3B3B3,BCAST,16'h86DD,0,3'b000,3'b000));
    // MAC miss, then promiscuous (promisc dropped mid-frame must not matter)
    tbl.push_back(mk(1,1,0,32'hC1C1C1C1,OTHER,16'h0800,0,3'b000,3'b000));
    tbl.push_back(mk(0,1,1,32'hC2C2C2C2,OTHER,16'h0800,0,3'b000,3'b000));
    tbl.push_back(mk(1,1,0,32'hD1D1D1D1,OTHER,16'h0800,1,3'b110,3'b000));
    tbl.push_back(mk(0,1,0,32'hD2D2D2D2,OTHER,16'h0800,0,3'b010,3'b000));
    tbl.push_back(mk(0,1,1,32'hD3D3D3D3,OTHER,16'h0800,0,3'b011,3'b000));
    // Runt, single-word frame, then stray word proving IDLE
    tbl.push_back(mk(0,0,1,32'h00000000,LMAC,16'h0800,0,3'b000,3'b000));
    tbl.push_back(mk(1,1,1,32'hDEADBEEF,LMAC,16'h0800,0,3'b111,3'b000));
    tbl.push_back(mk(0,1,0,32'h12345678,LMAC,16'h0800,0,3'b000,3'b000));
    // Lost end IP -> ARP
    tbl.push_back(mk(1,1,0,32'hE1E1E1E1,LMAC,16'h0800,0,3'b110,3'b000));
    tbl.push_back(mk(0,1,0,32'hE2E2E2E2,LMAC,16'h0800,0,3'b010,3'b000));
    tbl.push_back(mk(1,1,0,32'hE3E3E3E3,BCAST,16'h0806,0,3'b001,3'b110));
    tbl.push_back(mk(0,1,1,32'hE4E4E4E4,BCAST,16'h0806,0,3'b000,3'b011));
    // Lost end IP -> IP, with a payload gap
    tbl.push_back(mk(1,1,0,32'hF1F1F1F1,LMAC,16'h0800,0,3'b110,3'b000));
    tbl.push_back(mk(0,1,0,32'hF2F2F2F2,LMAC,16'h0800,0,3'b010,3'b000));
    tbl.push_back(mk(0,0,0,32'hF5F5F5F5,LMAC,16'h0800,0,3'b000,3'b000));
    tbl.push_back(mk(1,1,0,32'hF3F3F3F3,LMAC,16'h0800,0,3'b111,3'b000));
    tbl.push_back(mk(0,1,1,32'hF4F4F4F4,LMAC,16'h0800,0,3'b011,3'b000));
    // Multicast group address
    tbl.push_back(mk(1,1,0,32'h61616161,MCAST,16'h0800,0,3'b110,3'b000));
    tbl.push_back(mk(0,1,1,32'h62626262,MCAST,16'h0800,0,3'b011,3'b000));

    #12;
    check("reset_out", dut_out, 70'h0);
    check("reset_cnt", {6'h0, cnt_ip, cnt_arp, cnt_drop, cnt_runt}, 70'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].op, tbl[i].en, tbl[i].data, tbl[i].dest, tbl[i].ptype, tbl[i].prom);
      model_cycle();
      @(posedge clk);
      #1;
      check($sformatf("tbl_out[%0d]", i), dut_out,
            {tbl[i].ipb, tbl[i].ipb[1] ? tbl[i].data : 32'h0,
             tbl[i].arpb, tbl[i].arpb[1] ? tbl[i].data : 32'h0});
      check_counters();
    end
    check("tbl_cnt", {6'h0, cnt_ip, cnt_arp, cnt_drop, cnt_runt},
          {6'h0, 16'd7, 16'd2, 16'd2, 16'd1});

    // Asynchronous reset mid-frame; trailing words must be ignored
    drive(1, 1, 0, 32'h71717171, LMAC, 16'h0800, 0);
    cyc();
    drive(0, 1, 0, 32'h72727272, LMAC, 16'h0800, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", dut_out, 70'h0);
    check("async_reset_cnt", {6'h0, cnt_ip, cnt_arp, cnt_drop, cnt_runt}, 70'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    drive(0, 1, 0, 32'h73737373, LMAC, 16'h0800, 0);
    cyc();
    drive(0, 1, 1, 32'h74747474, LMAC, 16'h0800, 0);
    cyc();

    // Clear coinciding with a start wins over the increment
    drive(1, 1, 1, 32'h81818181, LMAC, 16'h0800, 0);
    cyc();
    check("pre_clr_cnt_ip", 70'(cnt_ip), 70'd1);
    clr = 1'b1;
    drive(1, 1, 1, 32'h82828282, LMAC, 16'h0800, 0);
    cyc();
    clr = 1'b0;
    check("clr_cnt_ip", 70'(cnt_ip), 70'd0);

    // 2^16+1 IP frames wrap the counter to 1
    for (int i = 0; i < 65537; i++) begin
      drive(1, 1, 1, i, LMAC, 16'h0800, 0);
      model_cycle();
      @(posedge clk);
    end
    #1;
    check("wrap_cnt_ip", 70'(cnt_ip), 70'd1);
    check_counters();

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      st   = ($urandom % 8) == 0;
      en   = ($urandom % 8) == 0;
      op   = $urandom % 2;
      data = $urandom;
      clr  = ($urandom % 64) == 0;
      if (st) begin
        case ($urandom % 5)
          0: dest = LMAC;
          1: dest = BCAST;
          2: dest = MCAST;
          3: dest = OTHER;
          default: dest = {16'($urandom), 32'($urandom)};
        endcase
        case ($urandom % 3)
          0: ptype = 16'h0800;
          1: ptype = 16'h0806;
          default: ptype = 16'h86DD;
        endcase
        prom = ($urandom % 4) == 0;
      end
      cyc();
    end
    clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
